// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//
// Purpose:
//   Receive-side PWM duty decoder. Over a fixed frame of 2^DWIDTH clock ticks
//   it counts the high time of each of STAGE PWM input lines, converts each
//   count to a saturated DWIDTH-bit duty word, captures all words at the end
//   of the frame and streams them out serially (channel 0 first) on a
//   valid/ready word interface.
//
// Parameters:
//   DWIDTH      duty word width; frame length is 2^DWIDTH clk cycles
//   STAGE       number of PWM input channels / words per frame
//
// Ports:
//   clk         single clock for the whole block
//   rst         synchronous, active-low reset
//   en          measurement enable; 0 holds frame counter and accumulators clear
//   pwm_in      PWM lines, bit i is channel i
//   data_out    duty word of the channel currently offered
//   data_valid  data_out valid, held until accepted
//   data_ready  downstream accepts when data_valid & data_ready at a clk edge
//   frame_first 1 while data_out carries channel 0 of a frame
//   overrun     one-cycle pulse: a frame ended while the previous one was
//               still unloading; that frame's data is dropped
//
// Build option:
//   PWM_CAPTURE_SYNC_EN  when defined, pwm_in passes through a 2-flop
//                        synchronizer per channel before measurement.
// ---------------------------------------------------------------------------
module pwm_capture #(
   parameter int DWIDTH = 8,
   parameter int STAGE  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [STAGE-1:0]  pwm_in,
   output logic [DWIDTH-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              frame_first,
   output logic              overrun
);

   localparam int IDXW = (STAGE > 1) ? $clog2(STAGE) : 1;
   localparam logic [DWIDTH-1:0] MAXV = '1;
   localparam logic [IDXW-1:0]   LAST = IDXW'(STAGE - 1);

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   // Saturating add of one sampled PWM bit to an accumulator.
   function automatic logic [DWIDTH-1:0] sat_add(input logic [DWIDTH-1:0] a,
                                                  input logic              b);
      logic [DWIDTH:0] sum;
      sum = {1'b0, a} + {{DWIDTH{1'b0}}, b};
      return sum[DWIDTH] ? MAXV : sum[DWIDTH-1:0];
   endfunction

   logic [STAGE-1:0]  w_s;
   logic [DWIDTH-1:0] r_frame_cnt;
   logic [DWIDTH-1:0] r_acc  [STAGE];
   logic [DWIDTH-1:0] r_hold [STAGE];
   logic [DWIDTH-1:0] w_sum  [STAGE];
   state_t            r_state, w_state_nx;
   logic [IDXW-1:0]   r_idx, w_idx_nx;
   logic              r_overrun;
   logic              w_eof, w_xfer, w_last, w_cap;

`ifdef PWM_CAPTURE_SYNC_EN
   logic [STAGE-1:0] r_sync1, r_sync2;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= pwm_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = r_sync2;
`else
   assign w_s = pwm_in;
`endif

   assign w_eof  = en && (r_frame_cnt == MAXV);
   assign w_xfer = (r_state == ST_SEND) && data_ready;
   assign w_last = (r_idx == LAST);
   // A new frame may only overwrite the hold registers when nothing is being
   // unloaded, or when the last word of the old frame leaves on this edge.
   assign w_cap  = w_eof && ((r_state == ST_IDLE) || (w_xfer && w_last));

   always_comb begin
      for (int i = 0; i < STAGE; i++) begin
         w_sum[i] = sat_add(r_acc[i], w_s[i]);
      end
   end

   // Frame counter, accumulators and capture registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_frame_cnt <= '0;
         for (int i = 0; i < STAGE; i++) begin
            r_acc[i]  <= '0;
            r_hold[i] <= '0;
         end
      end else if (!en) begin
         r_frame_cnt <= '0;
         for (int i = 0; i < STAGE; i++) begin
            r_acc[i] <= '0;
         end
      end else begin
         r_frame_cnt <= r_frame_cnt + 1'b1;
         for (int i = 0; i < STAGE; i++) begin
            if (w_eof) begin
               // Accumulators restart every frame, even when the capture is
               // blocked, so the following frame measures cleanly.
               r_acc[i] <= '0;
               if (w_cap) begin
                  r_hold[i] <= w_sum[i];
               end
            end else begin
               r_acc[i] <= w_sum[i];
            end
         end
      end
   end

   // Output FSM state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_idx     <= w_idx_nx;
         r_overrun <= w_eof && !w_cap;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_idx_nx    = r_idx;
      data_valid  = 1'b0;
      data_out    = '0;
      frame_first = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cap) begin
               w_state_nx = ST_SEND;
               w_idx_nx   = '0;
            end
         end
         ST_SEND: begin
            data_valid  = 1'b1;
            data_out    = r_hold[r_idx];
            frame_first = (r_idx == '0);
            if (w_xfer) begin
               if (w_last) begin
                  // Back-to-back frames: stay in SEND when a capture
                  // coincides with the last transfer.
                  w_state_nx = w_cap ? ST_SEND : ST_IDLE;
                  w_idx_nx   = '0;
               end else begin
                  w_idx_nx = r_idx + IDXW'(1);
               end
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_idx_nx   = '0;
         end
      endcase
   end

   assign overrun = r_overrun;

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

   localparam int DW = 8;
   localparam int NS = 8;
   localparam int FRAME = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [NS-1:0] pwm_in;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          data_ready;
   logic          frame_first;
   logic          overrun;

   pwm_capture #(.DWIDTH(DW), .STAGE(NS)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .pwm_in     (pwm_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .frame_first(frame_first),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              all_high;
      logic [7:0][7:0]   duty;
      logic [7:0][7:0]   exp;
   } vec_t;

   typedef struct packed {
      logic [7:0] word;
      logic       first;
   } sb_t;

   vec_t vec [4];
   sb_t  q [$];
   int   n_vec = 0;
   int   n_err = 0;
   int   vcyc = 0;
   int   ov_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NS-1:0] pat(input int k, input int c);
      logic [NS-1:0] p;
      for (int i = 0; i < NS; i++) begin
         p[i] = vec[k].all_high | (c < int'(vec[k].duty[i]));
      end
      return p;
   endfunction

   task automatic push_exp(input int k, input int nwords);
      sb_t e;
      for (int i = 0; i < nwords; i++) begin
         e.word  = vec[k].exp[i];
         e.first = (i == 0);
         q.push_back(e);
      end
   endtask

   // One full frame of generator stimulus, aligned with the DUT frame counter.
   task automatic run_frame(input int k);
      for (int c = 0; c < FRAME; c++) begin
         en     = 1'b1;
         pwm_in = pat(k, c);
         step();
      end
   endtask

   task automatic drain(input string name);
      data_ready = 1'b1;
      for (int i = 0; i < 40 && (q.size() != 0 || data_valid); i++) step();
      check(name, q.size(), 0);
   endtask

   // Scoreboard: compare every accepted word against the queue.
   always @(negedge clk) begin
      sb_t e;
      if (data_valid) vcyc++;
      if (overrun) ov_count++;
      if (data_valid && data_ready) begin
         if (q.size() == 0) begin
            check("unexpected_word", {data_out, frame_first}, 9'h1ff);
         end else begin
            e = q.pop_front();
            check("word", {data_out, frame_first}, {e.word, e.first});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] hold_w;
      logic          hold_f;
      logic          ok;

      // Stimulus table: generator duties per channel and the words expected back.
      vec[0].all_high = 1'b0;
      vec[0].duty = {8'd37, 8'd255, 8'd254, 8'd200, 8'd128, 8'd64, 8'd1, 8'd0};
      vec[0].exp  = {8'd37, 8'd255, 8'd254, 8'd200, 8'd128, 8'd64, 8'd1, 8'd0};
      vec[1].all_high = 1'b1;
      vec[1].duty = '0;
      vec[1].exp  = {8{8'd255}};
      vec[2].all_high = 1'b0;
      vec[2].duty = '0;
      vec[2].exp  = '0;
      vec[3].all_high = 1'b0;
      vec[3].duty = {8'd77, 8'd128, 8'd0, 8'd1, 8'd99, 8'd17, 8'd250, 8'd3};
      vec[3].exp  = {8'd77, 8'd128, 8'd0, 8'd1, 8'd99, 8'd17, 8'd250, 8'd3};

      rst = 1'b0; en = 1'b0; pwm_in = '0; data_ready = 1'b1;
      step(); step(); step();
      check("rst_data_out", data_out, 0);
      check("rst_data_valid", data_valid, 0);
      check("rst_frame_first", frame_first, 0);
      check("rst_overrun", overrun, 0);

      // Continuous frames with data_ready high.
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push_exp(k, NS);
         run_frame(k);
      end
      en = 1'b0; pwm_in = '0;
      for (int i = 0; i < 12; i++) step();
      check("stream_drained", q.size(), 0);
      check("stream_valid_cycles", vcyc, 4 * NS);
      check("stream_no_overrun", ov_count, 0);

      // Stall: data_ready low for 10 cycles after data_valid rises.
      data_ready = 1'b0;
      push_exp(0, NS);
      run_frame(0);
      en = 1'b0; pwm_in = '0;
      check("latency_valid", data_valid, 1);
      hold_w = data_out;
      hold_f = frame_first;
      check("stall_word0", {hold_w, hold_f}, {vec[0].exp[0], 1'b1});
      for (int i = 0; i < 10; i++) begin
         step();
         check("stall_stable", {data_valid, data_out, frame_first}, {1'b1, hold_w, hold_f});
      end
      drain("stall_drained");

      // Overrun: unload blocked across the next frame end.
      data_ready = 1'b0;
      push_exp(1, NS);
      run_frame(1);
      run_frame(2);
      en = 1'b0; pwm_in = '0;
      step(); step(); step();
      check("overrun_once", ov_count, 1);
      check("overrun_keeps_word0", {data_out, frame_first}, {vec[1].exp[0], 1'b1});
      drain("overrun_drained");

      // Reset while word 3 is pending.
      data_ready = 1'b0;
      push_exp(3, 3);
      run_frame(3);
      en = 1'b0; pwm_in = '0;
      data_ready = 1'b1;
      step(); step(); step();
      data_ready = 1'b0;
      check("pending_word3", {data_valid, data_out, frame_first}, {1'b1, vec[3].exp[3], 1'b0});
      rst = 1'b0;
      step();
      check("midrst_outputs", {data_valid, data_out, frame_first, overrun}, 0);

      // First frame after reset release: data_valid only after the full frame.
      rst = 1'b1;
      push_exp(2, NS);
      ok = 1'b1;
      for (int c = 0; c < FRAME; c++) begin
         en = 1'b1;
         pwm_in = pat(2, c);
         step();
         if (c < FRAME - 1 && data_valid) ok = 1'b0;
      end
      en = 1'b0; pwm_in = '0;
      check("post_rst_no_early_valid", ok, 1);
      check("post_rst_valid", data_valid, 1);
      drain("post_rst_drained");

      // en dropped at frame_cnt=100: partial frame discarded.
      data_ready = 1'b1;
      for (int c = 0; c < 100; c++) begin
         en = 1'b1;
         pwm_in = '1;
         step();
      end
      en = 1'b0; pwm_in = '0;
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         if (data_valid) ok = 1'b0;
      end
      check("partial_no_capture", ok, 1);
      push_exp(0, NS);
      run_frame(0);
      en = 1'b0; pwm_in = '0;
      drain("after_partial_drained");

      check("final_overrun_count", ov_count, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the STAGE-channel PWM generator.
- Measures the high time of STAGE PWM input lines over a fixed frame of 2^DWIDTH clock ticks and converts each to a DWIDTH-bit duty word.
- At each frame end it captures all STAGE words and streams them out serially, channel 0 first, on a valid/ready word interface.
- Used for loopback checking of the PWM output stage and for decoding externally generated PWM.

Parameters:
DWIDTH, 8, duty word width; frame length is 2^DWIDTH clk cycles
STAGE, 8, number of PWM input channels / words per frame

Ports:
clk  input  1  single clock for the whole block
rst  input  1  reset, synchronous, active-low (rst==0 at a clk rising edge resets)
en  input  1  measurement enable; 1 = frames run, 0 = frame counter and accumulators held cleared
pwm_in  input  STAGE  PWM lines; bit i is channel i
data_out  output  DWIDTH  duty word of the current channel
data_valid  output  1  data_out valid; held until accepted
data_ready  input  1  downstream accepts the word when data_valid and data_ready are both 1 at a clk edge
frame_first  output  1  1 while data_out carries channel 0 of a frame
overrun  output  1  one-cycle pulse: frame end hit while the previous frame was still unloading

Behaviour:
- Reset (rst==0): frame_cnt=0, all accumulators=0, hold regs=0, FSM=IDLE; data_out=0, data_valid=0, frame_first=0, overrun=0.
- Frame counter: DWIDTH bits; increments each cycle while en=1; wraps 2^DWIDTH-1 -> 0.
- End-of-frame (EOF) cycle: the cycle where en=1 and frame_cnt==2^DWIDTH-1.
- en=0: frame_cnt and accumulators cleared on the next edge. An unload already in progress still completes.
- First frame after en rises starts at frame_cnt=0 and is a full frame.
- Accumulation: each en=1 cycle, acc[i] += s[i], where s is the sampled pwm_in.
- Accumulator saturation: acc[i] saturates at 2^DWIDTH-1, so an all-high frame reads 2^DWIDTH-1.
- Generator correspondence: a generator with data=D (high while count<D) reads back exactly D for D=0..2^DWIDTH-1.
- EOF cycle: hold[i] <= sat(acc[i] + s[i]) and acc[i] <= 0 for all channels simultaneously, unless capture is blocked (see FSM rules).
- Output FSM, IDLE: data_valid=0. On an EOF cycle with capture -> SEND, idx=0.
- Output FSM, SEND: data_valid=1, data_out=hold[idx], frame_first=(idx==0).
- SEND handshake: on data_valid & data_ready, idx increments. On the transfer of idx==STAGE-1 -> IDLE.
- Latency: data_valid rises the cycle immediately after the EOF cycle. With data_ready tied high, all STAGE words leave in STAGE consecutive cycles.
- Handshake rule: data_out and frame_first stay stable while data_valid=1 and data_ready=0.
- Overrun: EOF while in SEND and not transferring the last word means hold is not updated, that frame's data is dropped, the unload continues unchanged, and overrun pulses for one cycle.
- Simultaneous EOF and last-word transfer: capture proceeds, no overrun, FSM stays in SEND with idx=0 (back-to-back frames).
- Reset mid-frame or mid-unload: the synchronous reset wins and all state returns to reset values on that edge; the partial frame is lost.
- data_ready is ignored in IDLE.

Optional Feature:
- Macro PWM_CAPTURE_SYNC_EN.
- Defined: pwm_in passes through a 2-flop synchronizer per channel; s = the synchronized value. Measured widths are unchanged but shifted 2 cycles relative to frame_cnt, so phase alignment with a generator changes and a pulse straddling a frame boundary is split across frames. Synchronizer flops reset to 0.
- Undefined: s = pwm_in directly (same-clock source assumed).

Test Plan:
- Same-clock generator drives channel i with D_i={0,1,64,128,200,254,255,37}, DWIDTH=8, sync off -> one frame later words 0,1,64,128,200,254,255,37 in order, frame_first only on word 0.
- pwm_in all 1s for a whole frame -> every word = 255 (saturation). All 0s -> every word = 0.
- data_ready held low 10 cycles after data_valid rises -> data_out and frame_first stable throughout; word 0 transferred on the first edge with data_ready=1.
- data_ready tied high, continuous frames -> 8 valid cycles per 256-cycle frame, no overrun. With data_ready=0 for more than 256 cycles -> overrun pulses once at the next EOF and the original words are still delivered.
- rst=0 asserted while word 3 is pending -> next cycle data_valid=0, all outputs 0. After reset release with en=1, the first words appear 257 cycles later.
- en dropped at frame_cnt=100 and re-raised -> no capture for the partial frame; the next full frame reports correct widths.
